// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared constants for the fetch-stage branch predictor
package branch_predictor_pkg;

    localparam int BP_INDEX_BITS = 3;

    // 2-bit saturating counter states; the MSB is the taken prediction
    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

endpackage

// File: rtl/CLA_16bit.sv
// rtl/CLA_16bit.sv - 16-bit carry-lookahead adder/subtractor, four 4-bit groups
module CLA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum
);

    logic [15:0] b_eff;
    logic [15:0] p;
    logic [15:0] g;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  pg;
    logic [4:0]  bc;

    assign b_eff = b ^ {16{sub}};
    assign p     = a ^ b_eff;
    assign g     = a & b_eff;

    always_comb begin
        gg = '0;
        pg = '0;
        bc = '0;
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            pg[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        // Group carries resolved by lookahead; only bit carries inside a group ripple
        bc[0] = sub;
        bc[1] = gg[0] | (pg[0] & bc[0]);
        bc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & bc[0]);
        bc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & bc[0]);
        bc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
              | (pg[3] & pg[2] & pg[1] & gg[0]) | (pg[3] & pg[2] & pg[1] & pg[0] & bc[0]);
        for (int k = 0; k < 4; k++) begin
            c[4*k] = bc[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        c[16] = bc[4];
    end

    assign sum = p ^ c[15:0];

endmodule

// File: rtl/sat_counter_2bit.sv
// rtl/sat_counter_2bit.sv - combinational next-state for a 2-bit saturating counter
module sat_counter_2bit
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_in,
    input  logic       inc,
    output logic [1:0] ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        if (inc) begin
            if (ctr_in != CTR_ST) ctr_out = ctr_in + 2'd1;
        end else begin
            if (ctr_in != CTR_SNT) ctr_out = ctr_in - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, fetch lookup and decode training
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] PC_curr,
    output logic        predicted_taken,
    output logic [15:0] predicted_target,
    output logic [15:0] PC_predicted,
    input  logic        update_en,
    input  logic        is_branch,
    input  logic [15:0] update_PC,
    input  logic        actual_taken,
    input  logic [15:0] actual_target,
    input  logic        update_pred_taken,
    input  logic [15:0] update_pred_target,
    output logic        mispredicted
);

    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam int TAG_W   = 15 - INDEX_BITS;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [15:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_hit;
    logic [15:0]           pc_plus2;

    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]      up_tag;
    logic                  up_hit;
    logic                  train;
    logic [1:0]            ctr_next;
    logic                  unused_pc_lsb;

    // Fetch-side lookup: halfword-aligned PC, bit 0 never selects an entry
    assign lk_idx = PC_curr[INDEX_BITS:1];
    assign lk_tag = PC_curr[15:INDEX_BITS+1];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    CLA_16bit u_pc_inc (
        .a   (PC_curr),
        .b   (16'h0002),
        .sub (1'b0),
        .sum (pc_plus2)
    );

    assign predicted_taken  = lk_hit & ctr_q[lk_idx][1];
    assign predicted_target = lk_hit ? target_q[lk_idx] : 16'h0000;
    assign PC_predicted     = predicted_taken ? predicted_target : pc_plus2;

    assign up_idx        = update_PC[INDEX_BITS:1];
    assign up_tag        = update_PC[15:INDEX_BITS+1];
    assign up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign train         = update_en & is_branch;
    assign unused_pc_lsb = update_PC[0];

    sat_counter_2bit u_ctr (
        .ctr_in  (ctr_q[up_idx]),
        .inc     (actual_taken),
        .ctr_out (ctr_next)
    );

    // A taken branch is wrong whenever the carried-down next PC differs from the real target
    assign mispredicted = train & (actual_taken ? (update_pred_target != actual_target)
                                                : update_pred_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 16'h0000;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (train) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_next;
                if (actual_taken) target_q[up_idx] <= actual_target;
            end else if (actual_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= actual_target;
                ctr_q[up_idx]    <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized and directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] PC_curr;
    logic        predicted_taken;
    logic [15:0] predicted_target;
    logic [15:0] PC_predicted;
    logic        update_en;
    logic        is_branch;
    logic [15:0] update_PC;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic        update_pred_taken;
    logic [15:0] update_pred_target;
    logic        mispredicted;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference state: one slot per index, tag kept as the PC divided by 16
    bit          m_valid  [8];
    int unsigned m_tag    [8];
    logic [15:0] m_target [8];
    int          m_ctr    [8];

    logic        obs_taken;
    logic [15:0] obs_target;
    logic [15:0] obs_pcp;
    logic        obs_mis;

    branch_predictor dut (
        .clk                (clk),
        .rst                (rst),
        .PC_curr            (PC_curr),
        .predicted_taken    (predicted_taken),
        .predicted_target   (predicted_target),
        .PC_predicted       (PC_predicted),
        .update_en          (update_en),
        .is_branch          (is_branch),
        .update_PC          (update_PC),
        .actual_taken       (actual_taken),
        .actual_target      (actual_target),
        .update_pred_taken  (update_pred_taken),
        .update_pred_target (update_pred_target),
        .mispredicted       (mispredicted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [15:0] pc);
        return int'(pc / 2) % 8;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 16'h0000;
            m_ctr[i]    = 1;
        end
    endtask

    task automatic model_lookup(input logic [15:0] pc, output logic tk,
                                output logic [15:0] tgt, output logic [15:0] pcp);
        int  i;
        bit  hit;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == int'(pc / 16));
        tgt = hit ? m_target[i] : 16'h0000;
        tk  = hit && (m_ctr[i] >= 2);
        pcp = tk ? tgt : 16'((int'(pc) + 2) % 65536);
    endtask

    task automatic model_train(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
        int i;
        bit hit;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == int'(pc / 16));
        if (hit) begin
            if (taken) begin
                m_ctr[i]    = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (taken) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = int'(pc / 16);
            m_target[i] = tgt;
            m_ctr[i]    = 2;
        end
    endtask

    // One clock: apply inputs, compare combinational outputs at negedge, advance model after posedge
    task automatic cycle(input logic r, input logic [15:0] pc, input logic ue, input logic br,
                         input logic [15:0] upc, input logic at, input logic [15:0] atgt,
                         input logic ptk, input logic [15:0] ptgt);
        logic        e_tk;
        logic [15:0] e_tgt;
        logic [15:0] e_pcp;
        logic        e_mis;
        rst = r; PC_curr = pc; update_en = ue; is_branch = br; update_PC = upc;
        actual_taken = at; actual_target = atgt;
        update_pred_taken = ptk; update_pred_target = ptgt;
        model_lookup(pc, e_tk, e_tgt, e_pcp);
        e_mis = ue && br && (at ? (ptgt != atgt) : ptk);
        @(negedge clk);
        obs_taken = predicted_taken; obs_target = predicted_target;
        obs_pcp = PC_predicted; obs_mis = mispredicted;
        check("predicted_taken", 32'(obs_taken), 32'(e_tk));
        check("predicted_target", 32'(obs_target), 32'(e_tgt));
        check("PC_predicted", 32'(obs_pcp), 32'(e_pcp));
        check("mispredicted", 32'(obs_mis), 32'(e_mis));
        @(posedge clk);
        if (r) model_reset();
        else if (ue && br) model_train(upc, at, atgt);
        #1;
    endtask

    task automatic idle(input logic [15:0] pc);
        cycle(1'b0, pc, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    // Branch update whose carried-down prediction is what the model predicts for that PC
    task automatic upd(input logic [15:0] pc, input logic [15:0] upc, input logic at,
                       input logic [15:0] atgt);
        logic        ptk;
        logic [15:0] ptgt;
        logic [15:0] pcp;
        model_lookup(upc, ptk, ptgt, pcp);
        cycle(1'b0, pc, 1'b1, 1'b1, upc, at, atgt, ptk, pcp);
    endtask

    initial begin
        logic        ptk;
        logic [15:0] ptgt;
        logic [15:0] pcp;
        logic [15:0] pool [6];
        rst = 1'b1; PC_curr = 16'h0; update_en = 1'b0; is_branch = 1'b0; update_PC = 16'h0;
        actual_taken = 1'b0; actual_target = 16'h0; update_pred_taken = 1'b0;
        update_pred_target = 16'h0;
        model_reset();
        @(posedge clk); #1;
        cycle(1'b1, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);

        for (int pc = 0; pc <= 32; pc += 2) begin
            idle(16'(pc));
            check("sweep_pcp", 32'(obs_pcp), 32'(pc + 2));
            check("sweep_taken", 32'(obs_taken), 32'd0);
        end

        upd(16'h0000, 16'h0010, 1'b1, 16'h0040);
        check("alloc_mispred", 32'(obs_mis), 32'd1);
        idle(16'h0010);
        check("alloc_taken", 32'(obs_taken), 32'd1);
        check("alloc_pcp", 32'(obs_pcp), 32'h0040);

        upd(16'h0010, 16'h0010, 1'b0, 16'h0000);
        idle(16'h0010);
        check("nt1_taken", 32'(obs_taken), 32'd0);
        upd(16'h0010, 16'h0010, 1'b0, 16'h0000);
        upd(16'h0010, 16'h0010, 1'b0, 16'h0000);
        for (int k = 0; k < 5; k++) begin
            upd(16'h0010, 16'h0010, 1'b1, 16'h0040);
            idle(16'h0010);
        end
        check("sat_taken", 32'(obs_taken), 32'd1);

        upd(16'h0010, 16'h0020, 1'b1, 16'h0100);
        idle(16'h0010);
        check("alias_miss", 32'(obs_taken), 32'd0);
        check("alias_pcp", 32'(obs_pcp), 32'h0012);
        upd(16'h0020, 16'h0030, 1'b0, 16'h0000);
        idle(16'h0020);
        check("alias_keep", 32'(obs_pcp), 32'h0100);

        upd(16'h0000, 16'h0010, 1'b1, 16'h0040);
        upd(16'h0010, 16'h0010, 1'b1, 16'h0200);
        check("br_same_cycle_old", 32'(obs_pcp), 32'h0040);
        check("br_mispred", 32'(obs_mis), 32'd1);
        idle(16'h0010);
        check("br_new_target", 32'(obs_pcp), 32'h0200);

        cycle(1'b1, 16'h0050, 1'b1, 1'b1, 16'h0050, 1'b1, 16'h0080, 1'b0, 16'h0052);
        idle(16'h0050);
        check("rst_update_dropped", 32'(obs_pcp), 32'h0052);
        idle(16'hFFFE);
        check("wrap_pcp", 32'(obs_pcp), 32'h0000);

        pool[0] = 16'h0010; pool[1] = 16'h0020; pool[2] = 16'h0030;
        pool[3] = 16'h0016; pool[4] = 16'hFFFE; pool[5] = 16'h1236;
        for (int n = 0; n < 600; n++) begin
            logic [15:0] upc;
            logic [15:0] cpc;
            logic        at;
            logic [15:0] atgt;
            upc  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 5)];
            cpc  = ($urandom_range(0, 1) == 0) ? upc : pool[$urandom_range(0, 5)];
            at   = 1'($urandom);
            atgt = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0040;
            model_lookup(upc, ptk, ptgt, pcp);
            if ($urandom_range(0, 4) == 0) begin
                ptk = 1'($urandom);
                pcp = 16'($urandom);
            end
            cycle(($urandom_range(0, 79) == 0), cpc, 1'($urandom), ($urandom_range(0, 3) != 0),
                  upc, at, atgt, ptk, pcp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
